// File: rtl/ex_fwd_scoreboard_if.sv
// EX-stage forwarding/hazard bundle between the decode/EX pipeline (master) and the scoreboard (slave).
// sbValid/sbRd/sbLd mirror the scoreboard entries (bit/slot k-1 = stage k) for debug and checking.
interface ex_fwd_scoreboard_if #(
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int REG_AW     = 5,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1),
  parameter int CNT_W      = 16
);
  // ex_valid qualifies every other ex_* field in the cycle it is high; ex_stall is the only
  // backpressure: while it is high the EX instruction is held and re-presented next cycle.
  logic                      ex_valid;
  logic                      ex_regwrite;
  logic                      ex_is_load;
  logic [REG_AW-1:0]         ex_rd;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic [NUM_SRC-1:0]        ex_rs_used;
  logic                      ex_flush;
  logic                      pipe_hold;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      ex_stall;
  logic [CNT_W-1:0]          stall_cnt;
  logic [FWD_STAGES-1:0]        sbValid;
  logic [FWD_STAGES*REG_AW-1:0] sbRd;
  logic [FWD_STAGES-1:0]        sbLd;

  modport master (
    output ex_valid, ex_regwrite, ex_is_load, ex_rd, ex_rs, ex_rs_used, ex_flush, pipe_hold,
    input  fwd_sel, ex_stall, stall_cnt, sbValid, sbRd, sbLd
  );

  modport slave (
    input  ex_valid, ex_regwrite, ex_is_load, ex_rd, ex_rs, ex_rs_used, ex_flush, pipe_hold,
    output fwd_sel, ex_stall, stall_cnt, sbValid, sbRd, sbLd
  );
endinterface

// File: rtl/ex_fwd_scoreboard.sv
// EX-stage forwarding select and load-use stall unit for the RV32I pipeline, backed by a
// private shift-register scoreboard of in-flight writers (stage 1 = MEM, stage 2 = WB, ...).
module ex_fwd_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int REG_AW     = 5,
  parameter int LOAD_RDY   = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1),
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic reset,
  ex_fwd_scoreboard_if.slave bus
);

  logic              entValid [1:FWD_STAGES];
  logic [REG_AW-1:0] entRd    [1:FWD_STAGES];
  logic              entLd    [1:FWD_STAGES];
  logic [CNT_W-1:0]  stallCnt;

  logic [NUM_SRC*SEL_W-1:0] selFlat;
  logic [NUM_SRC-1:0]       hazVec;
  logic [REG_AW-1:0]        rsCur;
  logic                     found;
  logic                     exLive;
  logic                     exStall;

  // A flushed or empty EX slot can neither forward nor stall.
  assign exLive = bus.ex_valid & ~bus.ex_flush;

  // Stage 1 is searched first, so the youngest producer of a register wins.
  always_comb begin
    selFlat = '0;
    hazVec  = '0;
    rsCur   = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rsCur = bus.ex_rs[i*REG_AW +: REG_AW];
      found = 1'b0;
      for (int k = 1; k <= FWD_STAGES; k++) begin
        if (!found && exLive && bus.ex_rs_used[i] && entValid[k] &&
            (entRd[k] != '0) && (entRd[k] == rsCur)) begin
          found                      = 1'b1;
          selFlat[i*SEL_W +: SEL_W]  = SEL_W'(k);
          hazVec[i]                  = (k < LOAD_RDY) && entLd[k];
        end
      end
    end
  end

  assign exStall = |hazVec;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        entValid[k] <= 1'b0;
        entRd[k]    <= '0;
        entLd[k]    <= 1'b0;
      end
      stallCnt <= '0;
    end else if (!bus.pipe_hold) begin
      for (int k = FWD_STAGES; k >= 2; k--) begin
        entValid[k] <= entValid[k-1];
        entRd[k]    <= entRd[k-1];
        entLd[k]    <= entLd[k-1];
      end
      // A stalled instruction stays in EX, so a bubble enters stage 1 instead.
      entValid[1] <= bus.ex_valid & bus.ex_regwrite & ~bus.ex_flush & ~exStall;
      entRd[1]    <= bus.ex_rd;
      entLd[1]    <= bus.ex_is_load;
      if (exStall && !(&stallCnt)) begin
        stallCnt <= stallCnt + 1'b1;
      end
    end
  end

  assign bus.fwd_sel   = selFlat;
  assign bus.ex_stall  = exStall;
  assign bus.stall_cnt = stallCnt;

  for (genvar k = 1; k <= FWD_STAGES; k++) begin : g_dbg
    assign bus.sbValid[k-1]                 = entValid[k];
    assign bus.sbRd[(k-1)*REG_AW +: REG_AW] = entRd[k];
    assign bus.sbLd[k-1]                    = entLd[k];
  end

endmodule
